sorted_block_drain: RTL and testbench
=====================================

// Module: sorted_block_drain
// PURPOSE
//  Downstream of the two-FIFO merge stage. Captures one merged block of DEPTH words into an
//  internal register file using the merge stage's write address and active-high write enable.
//  Once every entry is written, it streams the block out in address order on a valid/ready port.
//  It checks ascending order on the way out and reports any violation.
// PARAMETERS
//  WIDTH   8  data word width; must match the merge stage
//  DEPTH   8  entries per block (2 x input FIFO depth); 2..32
//  ADDR_W  5  write address width; matches the merge stage counter
// PORTS
//  clock       in   1        single clock; all logic on the rising edge
//  reset       in   1        synchronous, active-high
//  wr_en       in   1        active-high write strobe from the merge stage
//  wr_addr     in   ADDR_W   write address (merge stage count)
//  wr_data     in   WIDTH    merged word
//  out_valid   out  1        out_data holds a valid word
//  out_ready   in   1        consumer accepts the word when out_valid & out_ready
//  out_data    out  WIDTH    current word, mem[rd_ptr]
//  out_last    out  1        high with out_valid on the final word (rd_ptr == DEPTH-1)
//  busy        out  1        high in DRAIN; writes are not accepted
//  order_err   out  1        sticky: some word was below its predecessor within a block
//  wr_err      out  1        sticky: a write was dropped (addr >= DEPTH, or write during DRAIN)
//  block_cnt   out  8        number of completed blocks, wraps at 255
// BEHAVIOUR
//  Reset (reset==1 at an edge):
//   - state=FILL; written bitmap, rd_ptr, prev, block_cnt, order_err, wr_err all cleared.
//   - Outputs read 0, except out_data, which is a don't-care.
//   - Memory contents are not cleared.
//   - Reset mid-drain abandons the block; no partial out_last is issued.
//  FILL:
//   - A write with wr_en=1 and wr_addr<DEPTH stores mem[wr_addr] and sets written[wr_addr].
//   - A rewrite of the same address overwrites the data and is not double counted.
//   - wr_addr >= DEPTH: the write is dropped and wr_err is set.
//   - When the bitmap becomes all-ones (including the edge of the final write), go to DRAIN
//     at the next edge with rd_ptr=0. The first out_valid appears 1 cycle after the
//     completing write.
//  DRAIN:
//   - out_valid=1 and busy=1; out_data = mem[rd_ptr], a combinational read.
//   - out_data and out_last stay stable while out_ready=0.
//   - On a handshake:
//     - if rd_ptr>0 and out_data < prev (unsigned), set order_err;
//     - prev <= out_data; rd_ptr++.
//   - Handshake with out_last=1:
//     - clear the bitmap and rd_ptr; block_cnt++;
//     - go to FILL, with out_valid low the next cycle.
//   - Any wr_en in DRAIN is dropped and sets wr_err; it does not affect the next block's bitmap.
//  Boundary rules:
//   - order check restarts per block; the first word is never compared.
//   - wr_en in the same cycle as the final handshake is dropped (state is still DRAIN).
//   - block_cnt wraps 255 -> 0.
//   - The sticky flags clear only on reset.
//  FSM: FILL -> DRAIN (bitmap full); DRAIN -> FILL (last handshake).
//   - 1-bit state register; no other states.
// STRUCTURE
//  - Shared package: state encodings FILL/DRAIN and the default WIDTH/DEPTH/ADDR_W constants,
//    shared with the merge stage.
//  - One natural sub-module: sbd_regfile. It is a WIDTH x DEPTH array with one sync write
//    port and one async read port.
//  - The FSM, bitmap, pointer and checker stay in this top module.
// TESTING
//  1. Write addr 0..7 = 1,2,3,5,8,13,21,34, out_ready=1
//     -> out_valid 1 cycle after addr 7 write; 8 beats in order; out_last on 34; block_cnt=1.
//  2. Same block, out_ready toggling 1,0,0,1...
//     -> out_data/out_last held while stalled; exactly 8 handshakes; no duplicates or skips.
//  3. Write 4,9,7,10,... -> order_err rises after the handshake of 7, stays high into the next
//     clean block.
//  4. Write addr 3 twice, then addr 9, then the rest
//     -> second value is output at beat 3; wr_err=1; DRAIN only after all 8 addresses are written.
//  5. wr_en pulses during DRAIN -> wr_err=1; the next block still needs all 8 writes before
//     draining.
//  6. Assert reset at beat 4 of a drain
//     -> next cycle out_valid=0, block_cnt=0, flags 0; a fresh full block drains normally.

Source files
------------

// File: rtl/sorted_block_drain_pkg.sv
// sorted_block_drain_pkg
//   Shared constants and state encoding for the merge-stage / block-drain
//   pair. The default geometry must agree with the merge stage.
package sorted_block_drain_pkg;

  localparam int SBD_WIDTH  = 8;  // merged word width
  localparam int SBD_DEPTH  = 8;  // words per block (2 x input FIFO depth)
  localparam int SBD_ADDR_W = 5;  // merge-stage write counter width

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } sbd_state_e;

  // Register-file index width; never zero, so DEPTH=1-style corner cases
  // still elaborate.
  function automatic int sbd_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sorted_block_drain_if.sv
// sorted_block_drain_if
//   Write bus from the merge stage, valid/ready output stream and status.
//   slave  : the block drain itself
//   master : the surrounding logic (merge stage + consumer)
//   Signals:
//     wr_en/wr_addr/wr_data       merge-stage write port
//     out_valid/out_ready         output handshake
//     out_data/out_last           output word, last-of-block marker
//     busy/order_err/wr_err       status, sticky error flags
//     block_cnt                   completed block counter (wraps)
interface sorted_block_drain_if
  import sorted_block_drain_pkg::*;
#(
  parameter int WIDTH  = SBD_WIDTH,
  parameter int ADDR_W = SBD_ADDR_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              order_err;
  logic              wr_err;
  logic [7:0]        block_cnt;

  modport slave (
    input  wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_data, out_last, busy, order_err, wr_err, block_cnt
  );

  modport master (
    output wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_data, out_last, busy, order_err, wr_err, block_cnt
  );
endinterface

// File: rtl/sorted_block_drain_regfile.sv
// sbd_regfile
//   WIDTH x DEPTH storage, one synchronous write port, one asynchronous
//   read port. Contents are intentionally not reset.
//   Ports:
//     clock    in  rising-edge clock
//     we_i     in  write enable (caller guarantees waddr_i < DEPTH)
//     waddr_i  in  write index
//     wdata_i  in  write data
//     raddr_i  in  read index
//     rdata_o  out combinational read data
module sbd_regfile
  import sorted_block_drain_pkg::*;
#(
  parameter int WIDTH = SBD_WIDTH,
  parameter int DEPTH = SBD_DEPTH,
  parameter int IDX_W = sbd_idx_w(SBD_DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sorted_block_drain.sv
// sorted_block_drain
//   Collects one merged block of DEPTH words by address, then streams it out
//   in address order on a valid/ready port while checking that the words
//   are non-decreasing. Writes are only accepted while filling.
//   Ports:
//     clock   in  rising-edge clock
//     reset   in  synchronous, active-high
//     bus     slave modport of sorted_block_drain_if (write bus, output
//             stream, busy, sticky order_err/wr_err, block_cnt)
module sorted_block_drain
  import sorted_block_drain_pkg::*;
#(
  parameter int WIDTH  = SBD_WIDTH,
  parameter int DEPTH  = SBD_DEPTH,
  parameter int ADDR_W = SBD_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  sorted_block_drain_if.slave  bus
);

  localparam int IDX_W = sbd_idx_w(DEPTH);

  sbd_state_e        state_q, state_d;
  logic [DEPTH-1:0]  written_q, written_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              order_err_q, order_err_d;
  logic              wr_err_q, wr_err_d;

  logic [WIDTH-1:0]  rd_data;
  logic              addr_ok, wr_ok, drain, hs, last;

  // Compare in 32 bits: with DEPTH == 2**ADDR_W the bound does not fit in
  // ADDR_W bits.
  assign addr_ok = {{(32-ADDR_W){1'b0}}, bus.wr_addr} < 32'(DEPTH);
  assign drain   = (state_q == ST_DRAIN);
  assign wr_ok   = bus.wr_en && addr_ok && !drain;
  assign last    = drain && (rd_ptr_q == ADDR_W'(DEPTH-1));
  assign hs      = drain && bus.out_ready;

  sbd_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rf (
    .clock   (clock),
    .we_i    (wr_ok),
    .waddr_i (bus.wr_addr[IDX_W-1:0]),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q[IDX_W-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    written_d   = written_q;
    rd_ptr_d    = rd_ptr_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    order_err_d = order_err_q;
    wr_err_d    = wr_err_q;

    // Dropped writes: out of range, or anything arriving while draining
    // (including the cycle of the final handshake).
    if (bus.wr_en && (!addr_ok || drain)) wr_err_d = 1'b1;

    case (state_q)
      ST_FILL: begin
        if (wr_ok) begin
          // Rewrites just re-set the same bit, so they are not double counted.
          written_d = written_q | (DEPTH'(1) << bus.wr_addr[IDX_W-1:0]);
          if (&written_d) begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (hs) begin
          // First word of each block has no predecessor to compare against.
          if ((rd_ptr_q != '0) && (rd_data < prev_q)) order_err_d = 1'b1;
          prev_d = rd_data;
          if (last) begin
            written_d = '0;
            rd_ptr_d  = '0;
            cnt_d     = cnt_q + 8'd1;
            state_d   = ST_FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FILL;
      written_q   <= '0;
      rd_ptr_q    <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      order_err_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      written_q   <= written_d;
      rd_ptr_q    <= rd_ptr_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      order_err_q <= order_err_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign bus.out_valid = drain;
  assign bus.busy      = drain;
  assign bus.out_last  = last;
  assign bus.out_data  = rd_data;
  assign bus.order_err = order_err_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.block_cnt = cnt_q;

endmodule

// File: tb/tb_sorted_block_drain.sv
module tb_sorted_block_drain;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sorted_block_drain_if #(.WIDTH(8), .ADDR_W(5)) bus();

  sorted_block_drain #(.WIDTH(8), .DEPTH(8), .ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0][7:0] blk;

  typedef struct {
    logic       wr_en;
    logic [4:0] addr;
    logic [7:0] data;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [4:0] a, input logic [7:0] d,
                         input logic r, input logic ev, input logic [7:0] ed,
                         input logic el, input logic [7:0] ec);
    vecs[nv].wr_en   = we;  vecs[nv].addr   = a;  vecs[nv].data   = d;
    vecs[nv].rdy     = r;   vecs[nv].e_valid = ev; vecs[nv].e_data = ed;
    vecs[nv].e_last  = el;  vecs[nv].e_cnt  = ec;
    nv++;
  endtask

  task automatic set_blk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    blk[0] = a0; blk[1] = a1; blk[2] = a2; blk[3] = a3;
    blk[4] = a4; blk[5] = a5; blk[6] = a6; blk[7] = a7;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic write_blk();
    for (int i = 0; i < 8; i++) wr(5'(i), blk[i]);
  endtask

  // Handshakes nbeats words with out_ready=1; pmask pulses a write to addr 7
  // on the selected beats (must be dropped).
  task automatic drain(input int nbeats, input logic [7:0] pmask, input string tag);
    for (int i = 0; i < nbeats; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1);
      chk($sformatf("%s_busy%0d", tag, i), bus.busy, 1);
      chk($sformatf("%s_data%0d", tag, i), bus.out_data, blk[i]);
      chk($sformatf("%s_last%0d", tag, i), bus.out_last, (i == 7));
      bus.out_ready = 1'b1;
      bus.wr_en = pmask[i]; bus.wr_addr = 5'd7; bus.wr_data = 8'h00;
      @(negedge clock);
    end
    bus.out_ready = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b0;

    // Vector table: tests 1 and 2 cycle by cycle.
    set_blk(8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34);
    for (int i = 0; i < 8; i++) add_vec(1'b1, 5'(i), blk[i], 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) add_vec(1'b0, 5'd0, 8'h00, 1'b1, 1'b1, blk[i], (i == 7), 8'd0);
    for (int i = 0; i < 8; i++) add_vec(1'b1, 5'(i), blk[i], 1'b0, 1'b0, 8'h00, 1'b0, 8'd1);
    for (int k = 0; k < 22; k++) begin
      int b;
      b = (k + 2) / 3;
      add_vec(1'b0, 5'd0, 8'h00, (k % 3 == 0), 1'b1, blk[b], (b == 7), 8'd1);
    end
    add_vec(1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2);

    // Reset state
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_cnt", bus.block_cnt, 0);
    chk("rst_oerr", bus.order_err, 0);
    chk("rst_werr", bus.wr_err, 0);

    for (int n = 0; n < nv; n++) begin
      chk($sformatf("v%0d_valid", n), bus.out_valid, vecs[n].e_valid);
      chk($sformatf("v%0d_busy", n), bus.busy, vecs[n].e_valid);
      chk($sformatf("v%0d_last", n), bus.out_last, vecs[n].e_last);
      chk($sformatf("v%0d_cnt", n), bus.block_cnt, vecs[n].e_cnt);
      chk($sformatf("v%0d_oerr", n), bus.order_err, 0);
      chk($sformatf("v%0d_werr", n), bus.wr_err, 0);
      if (vecs[n].e_valid) chk($sformatf("v%0d_data", n), bus.out_data, vecs[n].e_data);
      bus.wr_en = vecs[n].wr_en; bus.wr_addr = vecs[n].addr;
      bus.wr_data = vecs[n].data; bus.out_ready = vecs[n].rdy;
      @(negedge clock);
    end
    bus.wr_en = 1'b0; bus.out_ready = 1'b0;

    // Test 3: order violation at word 7, sticky into next clean block
    set_blk(8'd4, 8'd9, 8'd7, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14);
    write_blk();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_oerr%0d", i), bus.order_err, (i >= 3));
      chk($sformatf("t3_data%0d", i), bus.out_data, blk[i]);
      bus.out_ready = 1'b1;
      @(negedge clock);
    end
    bus.out_ready = 1'b0;
    chk("t3_oerr_end", bus.order_err, 1);
    chk("t3_cnt", bus.block_cnt, 3);
    set_blk(8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34);
    write_blk();
    drain(8, 8'h00, "t3b");
    chk("t3b_oerr", bus.order_err, 1);
    chk("t3b_cnt", bus.block_cnt, 4);

    // Test 4: rewrite, out-of-range write, drain only when all written
    chk("t4_werr0", bus.wr_err, 0);
    wr(5'd3, 8'd99);
    wr(5'd3, 8'd40);
    chk("t4_werr_rewrite", bus.wr_err, 0);
    wr(5'd9, 8'd5);
    chk("t4_werr_oob", bus.wr_err, 1);
    wr(5'd0, 8'd10); wr(5'd1, 8'd20); wr(5'd2, 8'd30);
    wr(5'd4, 8'd50); wr(5'd5, 8'd60); wr(5'd6, 8'd70);
    chk("t4_valid_7of8", bus.out_valid, 0);
    chk("t4_busy_7of8", bus.busy, 0);
    wr(5'd7, 8'd80);
    set_blk(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80);
    drain(8, 8'h00, "t4");
    chk("t4_cnt", bus.block_cnt, 5);

    // Test 5: writes during drain are dropped, including on the last beat
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    chk("t5_rst_oerr", bus.order_err, 0);
    chk("t5_rst_werr", bus.wr_err, 0);
    chk("t5_rst_cnt", bus.block_cnt, 0);
    set_blk(8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34);
    write_blk();
    drain(8, 8'b1000_0100, "t5");
    chk("t5_werr", bus.wr_err, 1);
    chk("t5_cnt", bus.block_cnt, 1);
    chk("t5_valid_after", bus.out_valid, 0);
    for (int i = 0; i < 7; i++) wr(5'(i), blk[i]);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_wait_valid%0d", i), bus.out_valid, 0);
      @(negedge clock);
    end
    wr(5'd7, 8'd34);
    drain(8, 8'h00, "t5b");
    chk("t5b_cnt", bus.block_cnt, 2);

    // Test 6: reset mid-drain
    write_blk();
    drain(4, 8'h00, "t6");
    chk("t6_valid_b4", bus.out_valid, 1);
    chk("t6_data_b4", bus.out_data, blk[4]);
    reset = 1'b1; bus.out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0; bus.out_ready = 1'b0;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_last", bus.out_last, 0);
    chk("t6_cnt", bus.block_cnt, 0);
    chk("t6_werr", bus.wr_err, 0);
    chk("t6_oerr", bus.order_err, 0);
    set_blk(8'd3, 8'd6, 8'd9, 8'd12, 8'd15, 8'd18, 8'd21, 8'd24);
    for (int i = 0; i < 7; i++) wr(5'(i), blk[i]);
    chk("t6_valid_7of8", bus.out_valid, 0);
    wr(5'd7, blk[7]);
    drain(8, 8'h00, "t6b");
    chk("t6b_cnt", bus.block_cnt, 1);
    chk("t6b_oerr", bus.order_err, 0);
    chk("t6b_werr", bus.wr_err, 0);

    // block_cnt wrap 255 -> 0
    for (int b = 0; b < 254; b++) begin
      write_blk();
      drain(8, 8'h00, "wrap");
    end
    chk("cnt_255", bus.block_cnt, 255);
    write_blk();
    drain(8, 8'h00, "wrap_last");
    chk("cnt_wrap0", bus.block_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
